// File: rtl/ecemptcamip_axil_pkg.sv
// Shared constants for the ecemptcamip S00 AXI4-Lite register slave:
// register offsets, response codes and the two channel FSM encodings.
package ecemptcamip_axil_pkg;

    localparam int NUM_REGS = 4;

    // Byte offsets of the four control registers seen by the CAM core.
    localparam logic [3:0] REG0_OFF = 4'h0;
    localparam logic [3:0] REG1_OFF = 4'h4;
    localparam logic [3:0] REG2_OFF = 4'h8;
    localparam logic [3:0] REG3_OFF = 4'hC;

    // AXI response codes; only OKAY and SLVERR are ever issued.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel FSM encoding.
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_GOT_A = 2'd1;
    localparam logic [1:0] W_GOT_D = 2'd2;
    localparam logic [1:0] W_RESP  = 2'd3;

    // Read channel FSM encoding.
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    // Register index from a byte offset; the low two address bits are ignored.
    function automatic logic [1:0] reg_index(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/ecemptcamip_s00_axil_slave_if.sv
// AXI4-Lite bus bundle for the S00 port. The slave modport is used by the
// register slave, the master modport by whatever drives the bus.
interface ecemptcamip_s00_axil_slave_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

endinterface

// File: rtl/ecemptcamip_reg_bank.sv
// The four CAM control registers: byte-strobe merge on write commit,
// one-cycle write pulses and the combinational read mux.
module ecemptcamip_reg_bank
    import ecemptcamip_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [1:0]                            wr_sel,
    input  logic [DATA_WIDTH-1:0]                 wr_data,
    input  logic [DATA_WIDTH/8-1:0]               wr_strb,
    input  logic [1:0]                            rd_sel,
    output logic [DATA_WIDTH-1:0]                 rd_data,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                   reg_wr_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Merge enabled bytes into the selected register; pulse only when a byte actually landed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q        <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (wr_en) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (wr_strb[b]) begin
                        reg_q[wr_sel][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
                if (|wr_strb) begin
                    reg_wr_pulse[wr_sel] <= 1'b1;
                end
            end
        end
    end

    // Read mux sees the pre-commit contents, so a same-edge read returns the old value.
    assign rd_data = reg_q[rd_sel];

endmodule

// File: rtl/ecemptcamip_s00_axil_slave.sv
// AXI4-Lite slave for the ecemptcamip S00 port. Independent write and read
// channel FSMs in front of a four-register bank; out-of-range addresses get
// SLVERR. Readies depend only on FSM state and reset.
module ecemptcamip_s00_axil_slave
    import ecemptcamip_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                          s00_axi_aclk,
    input  logic                                          s00_axi_areset,
    ecemptcamip_s00_axil_slave_if.slave                   s00_axi,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]                           reg_wr_pulse
);

    localparam int STRB_WIDTH = C_S_AXI_DATA_WIDTH / 8;

    logic                          clk;
    logic                          rst;

    logic [1:0]                    w_state;
    logic [0:0]                    r_state;

    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0]         w_strb_q;
    logic [1:0]                    bresp_q;

    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;

    logic                          commit;
    logic [C_S_AXI_ADDR_WIDTH-1:0] cm_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0] cm_data;
    logic [STRB_WIDTH-1:0]         cm_strb;
    logic                          cm_err;

    logic                          unused_prot;

    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    // Protection attributes carry no meaning for this register map.
    assign unused_prot = ^{s00_axi.awprot, s00_axi.arprot};

    // Any set bit above the 16-byte register window is a decode error.
    function automatic logic addr_err(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
        return (a >> 4) != '0;
    endfunction

    assign s00_axi.awready = !rst && (w_state == W_IDLE || w_state == W_GOT_D);
    assign s00_axi.wready  = !rst && (w_state == W_IDLE || w_state == W_GOT_A);
    assign s00_axi.bvalid  = (w_state == W_RESP);
    assign s00_axi.bresp   = bresp_q;

    assign s00_axi.arready = !rst && (r_state == R_IDLE);
    assign s00_axi.rvalid  = (r_state == R_RESP);
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = rresp_q;

    assign aw_hs = s00_axi.awvalid && s00_axi.awready;
    assign w_hs  = s00_axi.wvalid  && s00_axi.wready;
    assign ar_hs = s00_axi.arvalid && s00_axi.arready;

    // Pick the commit address/data from the live bus or the latched half, per write state.
    always_comb begin
        commit  = 1'b0;
        cm_addr = aw_addr_q;
        cm_data = w_data_q;
        cm_strb = w_strb_q;
        case (w_state)
            W_IDLE: begin
                commit  = aw_hs && w_hs;
                cm_addr = s00_axi.awaddr;
                cm_data = s00_axi.wdata;
                cm_strb = s00_axi.wstrb;
            end
            W_GOT_A: begin
                commit  = w_hs;
                cm_data = s00_axi.wdata;
                cm_strb = s00_axi.wstrb;
            end
            W_GOT_D: begin
                commit  = aw_hs;
                cm_addr = s00_axi.awaddr;
            end
            default: begin
                commit = 1'b0;
            end
        endcase
    end

    assign cm_err = addr_err(cm_addr);

    // Write channel: collect AW and W in either order, then hold B until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        w_state <= W_RESP;
                    end else if (aw_hs) begin
                        w_state   <= W_GOT_A;
                        aw_addr_q <= s00_axi.awaddr;
                    end else if (w_hs) begin
                        w_state  <= W_GOT_D;
                        w_data_q <= s00_axi.wdata;
                        w_strb_q <= s00_axi.wstrb;
                    end
                end
                W_GOT_A: begin
                    if (commit) begin
                        w_state <= W_RESP;
                    end
                end
                W_GOT_D: begin
                    if (commit) begin
                        w_state <= W_RESP;
                    end
                end
                default: begin
                    if (s00_axi.bready) begin
                        w_state <= W_IDLE;
                    end
                end
            endcase
            if (commit) begin
                bresp_q <= cm_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Read channel: capture data and response at the AR handshake, hold until rready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state <= R_RESP;
                        if (addr_err(s00_axi.araddr)) begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end else begin
                            rdata_q <= rd_data;
                            rresp_q <= RESP_OKAY;
                        end
                    end
                end
                default: begin
                    if (s00_axi.rready) begin
                        r_state <= R_IDLE;
                    end
                end
            endcase
        end
    end

    ecemptcamip_reg_bank #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
    ) u_reg_bank (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (commit && !cm_err),
        .wr_sel       (reg_index(cm_addr[3:0])),
        .wr_data      (cm_data),
        .wr_strb      (cm_strb),
        .rd_sel       (reg_index(s00_axi.araddr[3:0])),
        .rd_data      (rd_data),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

endmodule

// File: tb/tb_ecemptcamip_s00_axil_slave.sv
// Bench for the S00 AXI4-Lite register slave: directed scenarios plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_ecemptcamip_s00_axil_slave;
    import ecemptcamip_axil_pkg::*;

    localparam int AW  = 6;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0][31:0] reg_q;
    logic [3:0]       reg_wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    bit   rand_rdy   = 1'b0;
    logic bready_dir = 1'b1;
    logic rready_dir = 1'b1;

    int p1_cnt = 0;

    // model state
    logic [31:0]   m_regs [4];
    bit            m_aw_held, m_w_held, m_b_pend, m_r_pend;
    logic [AW-1:0] m_a;
    logic [31:0]   m_d, m_rdata;
    logic [3:0]    m_s, m_pulse;
    logic [1:0]    m_bresp, m_rresp;
    bit            e_awr, e_wr;

    logic [3:0] offs [4];

    ecemptcamip_s00_axil_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    ecemptcamip_s00_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi        (bus),
        .reg_q          (reg_q),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_timeout(input string what);
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s actual=no_handshake required=handshake t=%0t", what, $time);
    endtask

    // Behavioural model: tracks which halves of a write are held and which
    // responses are outstanding; updates on each clock from the bus inputs.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 4; i++) m_regs[i] = '0;
                m_aw_held = 0; m_w_held = 0; m_b_pend = 0; m_r_pend = 0;
                m_a = '0; m_d = '0; m_s = '0; m_pulse = '0;
                m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
            end else begin
                e_awr   = !m_aw_held && !m_b_pend;
                e_wr    = !m_w_held && !m_b_pend;
                m_pulse = '0;
                if (m_r_pend) begin
                    if (bus.rready) m_r_pend = 0;
                end else if (bus.arvalid) begin
                    m_r_pend = 1;
                    if (bus.araddr >= AW'(16)) begin
                        m_rdata = '0;
                        m_rresp = RESP_SLVERR;
                    end else begin
                        m_rdata = m_regs[bus.araddr[3:2]];
                        m_rresp = RESP_OKAY;
                    end
                end
                if (m_b_pend) begin
                    if (bus.bready) m_b_pend = 0;
                end else begin
                    if (e_awr && bus.awvalid) begin
                        m_aw_held = 1;
                        m_a = bus.awaddr;
                    end
                    if (e_wr && bus.wvalid) begin
                        m_w_held = 1;
                        m_d = bus.wdata;
                        m_s = bus.wstrb;
                    end
                    if (m_aw_held && m_w_held) begin
                        if (m_a >= AW'(16)) begin
                            m_bresp = RESP_SLVERR;
                        end else begin
                            m_bresp = RESP_OKAY;
                            for (int i = 0; i < 4; i++)
                                if (m_s[i]) m_regs[m_a[3:2]][8*i +: 8] = m_d[8*i +: 8];
                            if (m_s != 4'b0000) m_pulse[m_a[3:2]] = 1'b1;
                        end
                        m_aw_held = 0;
                        m_w_held  = 0;
                        m_b_pend  = 1;
                    end
                end
            end
        end
    end

    // Compare DUT outputs with the model in the middle of every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_awready", 128'(bus.awready), 128'(0));
                chk("rst_wready",  128'(bus.wready),  128'(0));
                chk("rst_arready", 128'(bus.arready), 128'(0));
                chk("rst_bvalid",  128'(bus.bvalid),  128'(0));
                chk("rst_rvalid",  128'(bus.rvalid),  128'(0));
                chk("rst_bresp",   128'(bus.bresp),   128'(0));
                chk("rst_rresp",   128'(bus.rresp),   128'(0));
                chk("rst_rdata",   128'(bus.rdata),   128'(0));
                chk("rst_reg_q",   128'(reg_q),       128'(0));
                chk("rst_pulse",   128'(reg_wr_pulse), 128'(0));
            end else begin
                chk("awready", 128'(bus.awready), 128'(!m_aw_held && !m_b_pend));
                chk("wready",  128'(bus.wready),  128'(!m_w_held && !m_b_pend));
                chk("arready", 128'(bus.arready), 128'(!m_r_pend));
                chk("bvalid",  128'(bus.bvalid),  128'(m_b_pend));
                chk("rvalid",  128'(bus.rvalid),  128'(m_r_pend));
                if (m_b_pend) chk("bresp", 128'(bus.bresp), 128'(m_bresp));
                if (m_r_pend) begin
                    chk("rdata", 128'(bus.rdata), 128'(m_rdata));
                    chk("rresp", 128'(bus.rresp), 128'(m_rresp));
                end
                chk("reg_q", 128'(reg_q), {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
                chk("reg_wr_pulse", 128'(reg_wr_pulse), 128'(m_pulse));
                if (reg_wr_pulse[1]) p1_cnt++;
            end
        end
    end

    // Response-channel ready generation: directed level or random backpressure.
    initial begin
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.bready = rand_rdy ? ($urandom_range(0, 3) != 0) : bready_dir;
            bus.rready = rand_rdy ? ($urandom_range(0, 3) != 0) : rready_dir;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_aw(input logic [AW-1:0] a, input int d);
        bit got;
        repeat (d) begin @(posedge clk); #1; end
        bus.awaddr  = a;
        bus.awprot  = 3'($urandom);
        bus.awvalid = 1'b1;
        got = 0;
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (bus.awready) got = 1;
        end
        if (got) begin @(posedge clk); #1; end
        else do_timeout("aw");
        bus.awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] dat, input logic [3:0] s, input int d);
        bit got;
        repeat (d) begin @(posedge clk); #1; end
        bus.wdata  = dat;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        got = 0;
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (bus.wready) got = 1;
        end
        if (got) begin @(posedge clk); #1; end
        else do_timeout("w");
        bus.wvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] dat, input logic [3:0] s,
                             input int awd, input int wd, output logic [1:0] resp);
        bit got;
        resp = 2'b11;
        @(posedge clk);
        #1;
        fork
            drive_aw(a, awd);
            drive_w(dat, s, wd);
        join
        got = 0;
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (bus.bvalid && bus.bready) begin
                resp = bus.bresp;
                got  = 1;
            end
        end
        if (got) begin @(posedge clk); #1; end
        else do_timeout("b");
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] dat, output logic [1:0] resp);
        bit got;
        dat  = '1;
        resp = 2'b11;
        @(posedge clk);
        #1;
        bus.araddr  = a;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        got = 0;
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (bus.arready) got = 1;
        end
        if (got) begin @(posedge clk); #1; end
        else do_timeout("ar");
        bus.arvalid = 1'b0;
        got = 0;
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (bus.rvalid && bus.rready) begin
                dat  = bus.rdata;
                resp = bus.rresp;
                got  = 1;
            end
        end
        if (got) begin @(posedge clk); #1; end
        else do_timeout("r");
    endtask

    initial begin
        logic [31:0]   rd, rd2;
        logic [1:0]    rs, bs, rs2;
        logic [AW-1:0] wa, ra;
        logic [31:0]   wdat;
        logic [3:0]    wst;
        int            kind, p1_before;
        bit            got;

        offs[0] = REG0_OFF; offs[1] = REG1_OFF; offs[2] = REG2_OFF; offs[3] = REG3_OFF;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_reg_q", 128'(reg_q), 128'(0));
        chk("init_awready", 128'(bus.awready), 128'(1));

        // sequential write then read-back
        for (int i = 0; i < 4; i++) begin
            axi_write(AW'(offs[i]), 32'(i + 1), 4'hF, 0, 0, bs);
            chk("seq_bresp", 128'(bs), 128'(0));
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(AW'(offs[i]), rd, rs);
            chk("seq_rdata", 128'(rd), 128'(i + 1));
            chk("seq_rresp", 128'(rs), 128'(0));
        end

        // split channels: AW first, then W first
        axi_write(6'h08, 32'hDEADBEEF, 4'hF, 0, 3, bs);
        chk("split_aw_first", 128'(reg_q[2]), 128'(32'hDEADBEEF));
        axi_write(6'h0C, 32'hCAFEF00D, 4'hF, 2, 0, bs);
        chk("split_w_first", 128'(reg_q[3]), 128'(32'hCAFEF00D));

        // byte strobes
        axi_write(6'h04, 32'hFFFFFFFF, 4'hF, 0, 0, bs);
        p1_before = p1_cnt;
        axi_write(6'h04, 32'h12345678, 4'b0101, 0, 0, bs);
        chk("strb_pulse_cycles", 128'(p1_cnt - p1_before), 128'(1));
        axi_read(6'h04, rd, rs);
        chk("strb_rdata", 128'(rd), 128'(32'hFF34FF78));

        // write response backpressure
        bready_dir = 1'b0;
        fork
            axi_write(6'h00, 32'h00000011, 4'hF, 0, 0, bs);
            begin
                repeat (12) @(negedge clk);
                chk("bp_bvalid", 128'(bus.bvalid), 128'(1));
                chk("bp_awready", 128'(bus.awready), 128'(0));
                bready_dir = 1'b1;
            end
        join
        chk("bp_bresp", 128'(bs), 128'(0));

        // read response backpressure
        rready_dir = 1'b0;
        fork
            axi_read(6'h08, rd, rs);
            begin
                repeat (12) @(negedge clk);
                chk("bp_rvalid", 128'(bus.rvalid), 128'(1));
                chk("bp_arready", 128'(bus.arready), 128'(0));
                chk("bp_rdata_hold", 128'(bus.rdata), 128'(32'hDEADBEEF));
                rready_dir = 1'b1;
            end
        join
        chk("bp_rdata", 128'(rd), 128'(32'hDEADBEEF));

        // decode errors
        axi_write(6'h10, 32'h55555555, 4'hF, 0, 0, bs);
        chk("decerr_bresp", 128'(bs), 128'(2));
        chk("decerr_regs", 128'(reg_q), {32'hCAFEF00D, 32'hDEADBEEF, 32'hFF34FF78, 32'h00000011});
        axi_read(6'h20, rd, rs);
        chk("decerr_rdata", 128'(rd), 128'(0));
        chk("decerr_rresp", 128'(rs), 128'(2));

        // same-edge read and write commit to register 1
        fork
            axi_write(6'h04, 32'h000000AA, 4'hF, 0, 0, bs);
            axi_read(6'h04, rd, rs);
        join
        chk("collide_old", 128'(rd), 128'(32'hFF34FF78));
        axi_read(6'h04, rd, rs);
        chk("collide_new", 128'(rd), 128'(32'h000000AA));

        // randomized traffic
        rand_rdy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            wa   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            ra   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            wdat = $urandom;
            wst  = 4'($urandom);
            kind = int'($urandom_range(0, 2));
            case (kind)
                0: axi_write(wa, wdat, wst, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bs);
                1: axi_read(ra, rd, rs);
                default: fork
                    axi_write(wa, wdat, wst, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bs);
                    axi_read(ra, rd2, rs2);
                join
            endcase
        end
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset while holding an address without data
        bus.awaddr  = 6'h00;
        bus.awvalid = 1'b1;
        got = 0;
        for (int n = 0; n < TMO && !got; n++) begin
            @(negedge clk);
            if (bus.awready) got = 1;
        end
        if (!got) do_timeout("rst_aw");
        @(posedge clk);
        #1 bus.awvalid = 1'b0;
        @(negedge clk);
        chk("gota_awready", 128'(bus.awready), 128'(0));
        chk("gota_wready", 128'(bus.wready), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_awready", 128'(bus.awready), 128'(0));
        chk("arst_wready", 128'(bus.wready), 128'(0));
        chk("arst_reg_q", 128'(reg_q), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_bvalid", 128'(bus.bvalid), 128'(0));
        end
        chk("post_rst_reg_q", 128'(reg_q), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecemptcamip_s00_axil_slave.md
# ecemptcamip_s00_axil_slave

AXI4-Lite slave register interface for the ecemptcamip CAM IP, sitting at the S00_AXI port and responding to the system AXI4-Lite master. It exposes four 32-bit read/write control registers at offsets 0x0/0x4/0x8/0xC to the CAM core. It also implements independent write and read channel state machines with full backpressure handling, byte strobes and decode-error responses.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; must be ≥4.
- s00_axi_aclk  in  1  single clock; all logic rising-edge.
- s00_axi_areset  in  1  asynchronous, active-high reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  OKAY (00) or SLVERR (10).
- s00_axi_bvalid / s00_axi_bready  out / in  1  write-response handshake.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  read-address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  OKAY or SLVERR.
- s00_axi_rvalid / s00_axi_rready  out / in  1  read-data handshake.
- reg_q  out  4×32  current register contents to the CAM core; index = addr[3:2].
- reg_wr_pulse  out  4  one-cycle pulse per register on write commit.

## Operation
- Decode:
  - addr[3:2] selects the register; addr[1:0] is ignored.
  - Any nonzero bit in addr[C_S_AXI_ADDR_WIDTH-1:4] is a decode error: write dropped with SLVERR; read returns 0 with SLVERR.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
    - AW and W handshake in the same cycle → W_RESP.
    - AW only → W_GOT_A; address latched.
    - W only → W_GOT_D; data and strobes latched.
  - W_GOT_A: awready=0, wready=1. W handshake → W_RESP.
  - W_GOT_D: awready=1, wready=0. AW handshake → W_RESP.
  - W_RESP: both readies 0, bvalid=1. bready → W_IDLE.
- Write commit:
  - Occurs at the edge entering W_RESP.
  - Byte i of the selected register is updated only where wstrb[i]=1; wstrb=0000 commits nothing but still responds OKAY.
  - reg_wr_pulse[sel] is high in the first W_RESP cycle (0 on decode error or wstrb=0000).
- Read FSM states:
  - R_IDLE: arready=1. Handshake → R_RESP; rdata/rresp captured at that edge.
  - R_RESP: arready=0, rvalid=1, rdata stable. rready → R_IDLE.
- Read/write channels are fully independent. Same-edge collision: a read captured at the same edge as a write commit to the same register returns the pre-write value.
- bresp/bvalid and rdata/rresp/rvalid are held unchanged until the master accepts them.

## Timing
- Reset, asynchronous:
  - All registers 0; both FSMs go to IDLE.
  - bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, reg_wr_pulse=0.
  - All readies are forced 0 while reset is high.
- Reset mid-transaction abandons it immediately; no response is issued afterward.
- Write latency: last handshake (AW or W) at edge N → bvalid and the updated reg_q visible in cycle N+1.
- Read latency: AR handshake at edge N → rvalid in cycle N+1.
- Throughput: at most one write per 2 cycles and one read per 2 cycles when bready/rready are held high.
- No combinational path from any valid input to any ready output; readies depend only on FSM state and reset.

## Structure
- Package ecemptcamip_axil_pkg holds:
  - register offset constants REG0_OFF..REG3_OFF;
  - RESP_OKAY and RESP_SLVERR;
  - write FSM state enum (W_IDLE, W_GOT_A, W_GOT_D, W_RESP);
  - read FSM state enum (R_IDLE, R_RESP).
- One natural sub-module, ecemptcamip_reg_bank: the four registers, strobe merge, write pulses and read mux. Both FSMs stay in the top module.

## Test plan
- Sequential RW: write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC, then read back → each read returns the written value with rresp=00; each bresp=00.
- Split channels:
  - AW at 0x8 presented 3 cycles before W with data 0xDEADBEEF → awready low after the AW handshake; single bvalid one cycle after the W handshake; reg_q[2]=0xDEADBEEF.
  - W-before-AW order also covered.
- Strobes: reg1=0xFFFFFFFF, then write 0x12345678 with wstrb=0101 → reg1 reads 0xFF34FF78; reg_wr_pulse[1] high for exactly one cycle.
- Backpressure:
  - bready held low 10 cycles → bvalid/bresp stable and no new AW/W accepted.
  - rready held low 10 cycles → rdata stable and arready=0.
- Decode error (C_S_AXI_ADDR_WIDTH=6): write 0x10 → SLVERR, no register changes. Read 0x20 → rdata=0, rresp=10.
- Collision and reset:
  - Read of 0x4 captured on the same edge as a write commit of 0xAA to 0x4 → returns the old value; the next read returns 0xAA.
  - Reset asserted while in W_GOT_A → all outputs return to reset values, no bvalid afterward, all registers 0.
